// File: rtl/alu_pkg.sv
// Shared widths, ALU opcodes and the ID/EX pipeline register layout.
package alu_pkg;

   localparam int DATA_W     = 16;
   localparam int REG_ADDR_W = 4;

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;
   localparam logic [2:0] ALU_NAND = 3'b010;
   localparam logic [2:0] ALU_XOR  = 3'b011;
   localparam logic [2:0] ALU_INC  = 3'b100;
   localparam logic [2:0] ALU_SRA  = 3'b101;
   localparam logic [2:0] ALU_SRL  = 3'b110;
   localparam logic [2:0] ALU_SLL  = 3'b111;

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rs_addr;
      logic [REG_ADDR_W-1:0] rt_addr;
      logic [REG_ADDR_W-1:0] rd_addr;
      logic [DATA_W-1:0]     rs_data;
      logic [DATA_W-1:0]     rt_data;
      logic [DATA_W-1:0]     imm;
      logic                  use_imm;
      logic [3:0]            shamt;
      logic [2:0]            alu_op;
      logic                  reg_we;
      logic                  mem_rd;
      logic                  mem_wr;
   } id_ex_t;

   localparam id_ex_t ID_EX_BUBBLE = {$bits(id_ex_t){1'b0}};

endpackage

// File: rtl/fwd_mux.sv
// One operand's forwarding select: EX/MEM result beats MEM/WB data beats register file.
module fwd_mux
   import alu_pkg::*;
(
   input  logic [REG_ADDR_W-1:0] src_addr,
   input  logic [DATA_W-1:0]     reg_data,
   input  logic                  exm_reg_we,
   input  logic [REG_ADDR_W-1:0] exm_rd_addr,
   input  logic [DATA_W-1:0]     exm_result,
   input  logic                  mwb_reg_we,
   input  logic [REG_ADDR_W-1:0] mwb_rd_addr,
   input  logic [DATA_W-1:0]     mwb_data,
   output logic [DATA_W-1:0]     fwd_data
);

   logic src_nonzero_s;
   logic exm_hit_s;
   logic mwb_hit_s;

   assign src_nonzero_s = (src_addr != {REG_ADDR_W{1'b0}});
   assign exm_hit_s     = exm_reg_we & src_nonzero_s & (exm_rd_addr == src_addr);
   assign mwb_hit_s     = mwb_reg_we & src_nonzero_s & (mwb_rd_addr == src_addr);

   // Priority select of the freshest in-flight value.
   always_comb begin
      fwd_data = reg_data;
      if (exm_hit_s) begin
         fwd_data = exm_result;
      end else if (mwb_hit_s) begin
         fwd_data = mwb_data;
      end else begin
         fwd_data = reg_data;
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with rs/rt forwarding and a one-cycle load-use interlock.
module id_ex_stage
   import alu_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs_addr,
   input  logic [REG_ADDR_W-1:0] id_rt_addr,
   input  logic [REG_ADDR_W-1:0] id_rd_addr,
   input  logic [DATA_W-1:0]     id_rs_data,
   input  logic [DATA_W-1:0]     id_rt_data,
   input  logic [DATA_W-1:0]     id_imm,
   input  logic                  id_use_imm,
   input  logic [3:0]            id_shamt,
   input  logic [2:0]            id_alu_op,
   input  logic                  id_reg_we,
   input  logic                  id_mem_rd,
   input  logic                  id_mem_wr,
   input  logic                  exm_reg_we,
   input  logic [REG_ADDR_W-1:0] exm_rd_addr,
   input  logic [DATA_W-1:0]     exm_result,
   input  logic                  mwb_reg_we,
   input  logic [REG_ADDR_W-1:0] mwb_rd_addr,
   input  logic [DATA_W-1:0]     mwb_data,
   input  logic                  stall_in,
   input  logic                  flush,
   output logic                  id_ready,
   output logic                  ex_valid,
   output logic [DATA_W-1:0]     ex_data_one,
   output logic [DATA_W-1:0]     ex_data_two,
   output logic [3:0]            ex_shift,
   output logic [2:0]            ex_control,
   output logic [DATA_W-1:0]     ex_store_data,
   output logic [REG_ADDR_W-1:0] ex_rd_addr,
   output logic                  ex_reg_we,
   output logic                  ex_mem_rd,
   output logic                  ex_mem_wr
);

   id_ex_t            ex_r;
   id_ex_t            ex_next_s;
   id_ex_t            id_fields_s;
   logic              load_use_s;
   logic [DATA_W-1:0] fwd_rs_s;
   logic [DATA_W-1:0] fwd_rt_s;

   // A load in EX cannot feed a dependent in ID until it reaches WB.
   assign load_use_s = ex_r.valid & ex_r.mem_rd & ex_r.reg_we
                     & (ex_r.rd_addr != {REG_ADDR_W{1'b0}}) & id_valid
                     & ((id_rs_addr == ex_r.rd_addr) | (id_rt_addr == ex_r.rd_addr));

   assign id_ready = ~stall_in & ~load_use_s;

   assign id_fields_s = '{valid:   id_valid,
                          rs_addr: id_rs_addr,
                          rt_addr: id_rt_addr,
                          rd_addr: id_rd_addr,
                          rs_data: id_rs_data,
                          rt_data: id_rt_data,
                          imm:     id_imm,
                          use_imm: id_use_imm,
                          shamt:   id_shamt,
                          alu_op:  id_alu_op,
                          reg_we:  id_reg_we,
                          mem_rd:  id_mem_rd,
                          mem_wr:  id_mem_wr};

   // Next-state select: flush > stall > load-use bubble > capture.
   always_comb begin
      ex_next_s = ID_EX_BUBBLE;
      if (flush) begin
         ex_next_s = ID_EX_BUBBLE;
      end else if (stall_in) begin
         ex_next_s = ex_r;
      end else if (load_use_s) begin
         ex_next_s = ID_EX_BUBBLE;
      end else if (id_valid) begin
         ex_next_s = id_fields_s;
      end else begin
         ex_next_s = ID_EX_BUBBLE;
      end
   end

   // EX register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_r <= ID_EX_BUBBLE;
      end else begin
         ex_r <= ex_next_s;
      end
   end

   fwd_mux u_fwd_rs (
      .src_addr    (ex_r.rs_addr),
      .reg_data    (ex_r.rs_data),
      .exm_reg_we  (exm_reg_we),
      .exm_rd_addr (exm_rd_addr),
      .exm_result  (exm_result),
      .mwb_reg_we  (mwb_reg_we),
      .mwb_rd_addr (mwb_rd_addr),
      .mwb_data    (mwb_data),
      .fwd_data    (fwd_rs_s)
   );

   fwd_mux u_fwd_rt (
      .src_addr    (ex_r.rt_addr),
      .reg_data    (ex_r.rt_data),
      .exm_reg_we  (exm_reg_we),
      .exm_rd_addr (exm_rd_addr),
      .exm_result  (exm_result),
      .mwb_reg_we  (mwb_reg_we),
      .mwb_rd_addr (mwb_rd_addr),
      .mwb_data    (mwb_data),
      .fwd_data    (fwd_rt_s)
   );

   assign ex_valid      = ex_r.valid;
   assign ex_data_one   = fwd_rs_s;
   assign ex_data_two   = ex_r.use_imm ? ex_r.imm : fwd_rt_s;
   assign ex_store_data = fwd_rt_s;
   assign ex_shift      = ex_r.shamt;
   assign ex_control    = ex_r.alu_op;
   assign ex_rd_addr    = ex_r.rd_addr;
   assign ex_reg_we     = ex_r.reg_we;
   assign ex_mem_rd     = ex_r.mem_rd;
   assign ex_mem_wr     = ex_r.mem_wr;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed and randomized bench for id_ex_stage against a behavioural pipeline model.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst, id_valid, id_use_imm, id_reg_we, id_mem_rd, id_mem_wr;
   logic [3:0]  id_rs_addr, id_rt_addr, id_rd_addr, id_shamt;
   logic [15:0] id_rs_data, id_rt_data, id_imm;
   logic [2:0]  id_alu_op;
   logic        exm_reg_we, mwb_reg_we, stall_in, flush;
   logic [3:0]  exm_rd_addr, mwb_rd_addr;
   logic [15:0] exm_result, mwb_data;
   logic        id_ready, ex_valid, ex_reg_we, ex_mem_rd, ex_mem_wr;
   logic [15:0] ex_data_one, ex_data_two, ex_store_data;
   logic [3:0]  ex_shift, ex_rd_addr;
   logic [2:0]  ex_control;

   int n_cmp = 0;
   int n_bad = 0;

   // Model of the instruction currently in EX (zeroed means bubble).
   typedef struct {
      logic        valid, use_imm, we, mrd, mwr;
      logic [3:0]  rs, rt, rd, sh;
      logic [15:0] rsd, rtd, imm;
      logic [2:0]  op;
   } instr_t;

   instr_t m_ex, bubble;

   id_ex_stage dut (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
      .id_use_imm(id_use_imm), .id_shamt(id_shamt), .id_alu_op(id_alu_op),
      .id_reg_we(id_reg_we), .id_mem_rd(id_mem_rd), .id_mem_wr(id_mem_wr),
      .exm_reg_we(exm_reg_we), .exm_rd_addr(exm_rd_addr), .exm_result(exm_result),
      .mwb_reg_we(mwb_reg_we), .mwb_rd_addr(mwb_rd_addr), .mwb_data(mwb_data),
      .stall_in(stall_in), .flush(flush), .id_ready(id_ready),
      .ex_valid(ex_valid), .ex_data_one(ex_data_one), .ex_data_two(ex_data_two),
      .ex_shift(ex_shift), .ex_control(ex_control), .ex_store_data(ex_store_data),
      .ex_rd_addr(ex_rd_addr), .ex_reg_we(ex_reg_we), .ex_mem_rd(ex_mem_rd),
      .ex_mem_wr(ex_mem_wr)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %h, expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Newest producer wins; register 0 is never forwarded.
   function automatic logic [15:0] ref_operand(input logic [3:0] a, input logic [15:0] rf);
      logic [3:0]  src_addr [2];
      logic        src_we   [2];
      logic [15:0] src_val  [2];
      src_addr = '{exm_rd_addr, mwb_rd_addr};
      src_we   = '{exm_reg_we, mwb_reg_we};
      src_val  = '{exm_result, mwb_data};
      if (a == 4'd0) return rf;
      for (int k = 0; k < 2; k++)
         if (src_we[k] && src_addr[k] == a) return src_val[k];
      return rf;
   endfunction

   function automatic instr_t id_instr();
      instr_t t;
      t.valid = id_valid; t.rs = id_rs_addr; t.rt = id_rt_addr; t.rd = id_rd_addr;
      t.rsd = id_rs_data; t.rtd = id_rt_data; t.imm = id_imm; t.use_imm = id_use_imm;
      t.sh = id_shamt; t.op = id_alu_op; t.we = id_reg_we; t.mrd = id_mem_rd; t.mwr = id_mem_wr;
      return t;
   endfunction

   // Compare all outputs with the model, then advance model and DUT one clock.
   task automatic step();
      logic hazard;
      instr_t nxt;
      #1;
      hazard = m_ex.valid && m_ex.mrd && m_ex.we && m_ex.rd != 4'd0 && id_valid
               && (id_rs_addr == m_ex.rd || id_rt_addr == m_ex.rd);
      check_val("id_ready",   {31'd0, id_ready}, {31'd0, !stall_in && !hazard});
      check_val("ex_valid",   {31'd0, ex_valid}, {31'd0, m_ex.valid});
      check_val("data_one",   {16'd0, ex_data_one}, {16'd0, ref_operand(m_ex.rs, m_ex.rsd)});
      check_val("data_two",   {16'd0, ex_data_two},
                {16'd0, m_ex.use_imm ? m_ex.imm : ref_operand(m_ex.rt, m_ex.rtd)});
      check_val("store_data", {16'd0, ex_store_data}, {16'd0, ref_operand(m_ex.rt, m_ex.rtd)});
      check_val("shift",      {28'd0, ex_shift}, {28'd0, m_ex.sh});
      check_val("control",    {29'd0, ex_control}, {29'd0, m_ex.op});
      check_val("rd_addr",    {28'd0, ex_rd_addr}, {28'd0, m_ex.rd});
      check_val("ctl_bits",   {29'd0, ex_reg_we, ex_mem_rd, ex_mem_wr}, {29'd0, m_ex.we, m_ex.mrd, m_ex.mwr});
      if (rst || flush)           nxt = bubble;
      else if (stall_in)          nxt = m_ex;
      else if (hazard || !id_valid) nxt = bubble;
      else                        nxt = id_instr();
      @(posedge clk);
      m_ex = nxt;
      @(negedge clk);
   endtask

   task automatic set_id(input logic v, input logic [3:0] rs, input logic [3:0] rt, input logic [3:0] rd,
                         input logic [15:0] rsd, input logic [15:0] rtd, input logic [15:0] imm,
                         input logic ui, input logic [3:0] sh, input logic [2:0] op,
                         input logic we, input logic mrd, input logic mwr);
      id_valid = v; id_rs_addr = rs; id_rt_addr = rt; id_rd_addr = rd;
      id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_use_imm = ui;
      id_shamt = sh; id_alu_op = op; id_reg_we = we; id_mem_rd = mrd; id_mem_wr = mwr;
   endtask

   task automatic set_fwd(input logic ew, input logic [3:0] ea, input logic [15:0] ed,
                          input logic mw, input logic [3:0] ma, input logic [15:0] md);
      exm_reg_we = ew; exm_rd_addr = ea; exm_result = ed;
      mwb_reg_we = mw; mwb_rd_addr = ma; mwb_data = md;
   endtask

   initial begin
      bubble = '{default: '0};
      m_ex   = bubble;
      rst = 1'b1; stall_in = 1'b0; flush = 1'b0;
      set_fwd(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
      set_id(1'b1, 4'd1, 4'd2, 4'd3, 16'h1111, 16'h2222, 16'h3333, 1'b0, 4'd1, 3'b010, 1'b1, 1'b0, 1'b0);
      @(negedge clk);

      // Reset held two cycles with a valid instruction in decode
      step(); step();
      rst = 1'b0;
      #1;
      check_val("rst_valid",  {31'd0, ex_valid}, 32'd0);
      check_val("rst_ctrl",   {29'd0, ex_control}, 32'd0);
      check_val("rst_d1",     {16'd0, ex_data_one}, 32'd0);
      check_val("rst_d2",     {16'd0, ex_data_two}, 32'd0);
      check_val("rst_ready",  {31'd0, id_ready}, 32'd1);

      // No hazard ADD
      set_id(1'b1, 4'd1, 4'd2, 4'd3, 16'h0005, 16'h0007, 16'h0000, 1'b0, 4'd0, 3'b000, 1'b1, 1'b0, 1'b0);
      step();
      set_id(1'b0, 4'd0, 4'd0, 4'd0, 16'd0, 16'd0, 16'd0, 1'b0, 4'd0, 3'b000, 1'b0, 1'b0, 1'b0);
      #1;
      check_val("add_d1",    {16'd0, ex_data_one}, 32'h0005);
      check_val("add_d2",    {16'd0, ex_data_two}, 32'h0007);
      check_val("add_ctrl",  {29'd0, ex_control}, 32'd0);
      check_val("add_valid", {31'd0, ex_valid}, 32'd1);

      // Forwarding priority on rs=1
      set_fwd(1'b1, 4'd1, 16'h1234, 1'b1, 4'd1, 16'hBEEF);
      #1 check_val("fwd_exm", {16'd0, ex_data_one}, 32'h1234);
      exm_reg_we = 1'b0;
      #1 check_val("fwd_mwb", {16'd0, ex_data_one}, 32'hBEEF);
      set_fwd(1'b1, 4'd0, 16'h1234, 1'b1, 4'd0, 16'hBEEF);
      #1 check_val("fwd_rf0", {16'd0, ex_data_one}, 32'h0005);
      set_fwd(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);

      // Load-use: load to r4, then SUB reading r4
      set_id(1'b1, 4'd0, 4'd0, 4'd4, 16'd0, 16'd0, 16'h0008, 1'b1, 4'd0, 3'b000, 1'b1, 1'b1, 1'b0);
      step();
      set_id(1'b1, 4'd4, 4'd2, 4'd5, 16'h0000, 16'h0007, 16'd0, 1'b0, 4'd0, 3'b001, 1'b1, 1'b0, 1'b0);
      #1 check_val("lu_ready0", {31'd0, id_ready}, 32'd0);
      step();
      #1;
      check_val("lu_bub_valid", {31'd0, ex_valid}, 32'd0);
      check_val("lu_bub_we",    {31'd0, ex_reg_we}, 32'd0);
      check_val("lu_ready1",    {31'd0, id_ready}, 32'd1);
      set_fwd(1'b0, 4'd0, 16'd0, 1'b1, 4'd4, 16'h00FF);
      step();
      #1;
      check_val("lu_fwd",   {16'd0, ex_data_one}, 32'h00FF);
      check_val("lu_valid", {31'd0, ex_valid}, 32'd1);

      // Stall three cycles, then stall with flush
      stall_in = 1'b1;
      set_id(1'b1, 4'd1, 4'd2, 4'd6, 16'h0101, 16'h0202, 16'd0, 1'b0, 4'd2, 3'b011, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         #1;
         check_val("stall_ready", {31'd0, id_ready}, 32'd0);
         check_val("stall_ctrl",  {29'd0, ex_control}, 32'd1);
         check_val("stall_d1",    {16'd0, ex_data_one}, 32'h00FF);
         step();
      end
      flush = 1'b1;
      step();
      stall_in = 1'b0; flush = 1'b0;
      #1 check_val("flush_bubble", {31'd0, ex_valid}, 32'd0);
      set_fwd(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);

      // Immediate SLL with rt forwarded
      set_id(1'b1, 4'd1, 4'd5, 4'd7, 16'h0001, 16'h1111, 16'h0010, 1'b1, 4'd3, 3'b111, 1'b1, 1'b0, 1'b0);
      set_fwd(1'b1, 4'd5, 16'hAAAA, 1'b0, 4'd0, 16'd0);
      step();
      #1;
      check_val("imm_d2",    {16'd0, ex_data_two}, 32'h0010);
      check_val("imm_shift", {28'd0, ex_shift}, 32'd3);
      check_val("imm_ctrl",  {29'd0, ex_control}, 32'd7);
      check_val("imm_store", {16'd0, ex_store_data}, 32'hAAAA);

      // Randomized traffic with narrow register range to provoke hazards
      for (int c = 0; c < 800; c++) begin
         rst      = ($urandom % 40) == 0;
         flush    = ($urandom % 12) == 0;
         stall_in = ($urandom % 6) == 0;
         set_id(($urandom % 4) != 0, 4'($urandom % 5), 4'($urandom % 5), 4'($urandom % 5),
                16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom),
                4'($urandom), 3'($urandom), ($urandom % 4) != 0, ($urandom % 3) == 0, 1'($urandom));
         set_fwd(1'($urandom), 4'($urandom % 5), 16'($urandom),
                 1'($urandom), 4'($urandom % 5), 16'($urandom));
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
